// File: rtl/mem_responder.sv
// Single-port 16-bit word memory behind a Req/Ack handshake with a fixed wait latency.
// Optional upper-address range checking is enabled by defining MEM_RESPONDER_RANGECHK_EN.
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        We,
  input  logic [15:0] Addr,
  input  logic [15:0] Wdata,
  output logic [15:0] Rdata,
  output logic        Ack,
  output logic        Busy,
  output logic        Err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [15:0]       addr_reg;
  logic [15:0]       wdata_reg;
  logic              we_reg;
  logic              err_reg;
  logic [15:0]       rdata_reg;

  logic              accept;
  logic              enter_ack;
  logic [15:0]       acc_addr;
  logic [15:0]       acc_wdata;
  logic              acc_we;
  logic              acc_oob;
  logic [ADDR_W-1:0] acc_index;
  logic              mem_wr;

  logic [15:0]       mem [DEPTH];

  assign accept = (state_reg == ST_IDLE) && Req;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_ack  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (Req) begin
          cnt_next = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_next = ST_ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = ST_ACK;
          enter_ack  = 1'b1;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // With zero wait cycles the access happens on the acceptance edge itself,
  // so the live inputs are used instead of the not-yet-latched copies.
  always_comb begin
    if (state_reg == ST_IDLE) begin
      acc_addr  = Addr;
      acc_wdata = Wdata;
      acc_we    = We;
    end else begin
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
      acc_we    = we_reg;
    end
  end

  assign acc_index = acc_addr[ADDR_W-1:0];

`ifdef MEM_RESPONDER_RANGECHK_EN
  assign acc_oob = |acc_addr[15:ADDR_W];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = |acc_addr[15:ADDR_W];
  assign acc_oob           = 1'b0;
`endif

  assign mem_wr = enter_ack && acc_we && !acc_oob && Reset_n;

  // Array storage carries no reset so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (mem_wr) begin
      mem[acc_index] <= acc_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 16'h0000;
      wdata_reg <= 16'h0000;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 16'h0000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= Addr;
        wdata_reg <= Wdata;
        we_reg    <= We;
      end
      err_reg <= enter_ack && acc_oob;
      // Rdata only moves on a completing read; writes leave it untouched.
      if (enter_ack && !acc_we) begin
        rdata_reg <= acc_oob ? 16'h0000 : mem[acc_index];
      end
    end
  end

  assign Ack   = (state_reg == ST_ACK);
  assign Busy  = (state_reg != ST_IDLE);
  assign Err   = err_reg;
  assign Rdata = rdata_reg;

endmodule
